// File: rtl/rom_arbiter_if.sv
// rom_arbiter_if: requester, ROM and status signals of the two-port ROM arbiter.
interface rom_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              hold;
  logic              req0;
  logic              req1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic              gnt0;
  logic              gnt1;
  logic              rd_valid0;
  logic              rd_valid1;
  logic [DATA_W-1:0] rd_data0;
  logic [DATA_W-1:0] rd_data1;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_q;
  logic              busy;
  modport master (
    output hold, req0, req1, addr0, addr1, rom_q,
    input  gnt0, gnt1, rd_valid0, rd_valid1, rd_data0, rd_data1, rom_addr, busy
  );
  modport slave (
    input  hold, req0, req1, addr0, addr1, rom_q,
    output gnt0, gnt1, rd_valid0, rd_valid1, rd_data0, rd_data1, rom_addr, busy
  );
endinterface

// File: rtl/rom_arbiter.sv
// rom_arbiter: round-robin sharing of one pipelined ROM between two requesters,
// with a {valid, id} tag pipeline steering returned data back to its requester.
module rom_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int ROM_LAT = 1
) (
  input logic          sys_clk,
  input logic          sys_rst_n,
  rom_arbiter_if.slave bus
);
  logic              gnt0, gnt1, acc;
  logic              ptr_q, ptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ROM_LAT:0]  vld_q, vld_d, id_q, id_d;
  logic              v0_q, v0_d, v1_q, v1_d;
  logic [DATA_W-1:0] d0_q, d0_d, d1_q, d1_d;
  // ptr_q is the id granted last; reset to 1 so requester 0 wins the first contest
  always_comb begin
    gnt0   = sys_rst_n & ~bus.hold & bus.req0 & (~bus.req1 | ptr_q);
    gnt1   = sys_rst_n & ~bus.hold & bus.req1 & ~gnt0;
    acc    = gnt0 | gnt1;
    ptr_d  = acc ? gnt1 : ptr_q;
    addr_d = gnt0 ? bus.addr0 : gnt1 ? bus.addr1 : addr_q;
    vld_d  = {vld_q[ROM_LAT-1:0], acc};
    id_d   = {id_q[ROM_LAT-1:0], gnt1};
    v0_d   = vld_q[ROM_LAT] & ~id_q[ROM_LAT];
    v1_d   = vld_q[ROM_LAT] & id_q[ROM_LAT];
    d0_d   = v0_d ? bus.rom_q : d0_q;
    d1_d   = v1_d ? bus.rom_q : d1_q;
  end
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      ptr_q  <= 1'b1;
      addr_q <= '0;
      vld_q  <= '0;
      id_q   <= '0;
      v0_q   <= 1'b0;
      v1_q   <= 1'b0;
      d0_q   <= '0;
      d1_q   <= '0;
    end else begin
      ptr_q  <= ptr_d;
      addr_q <= addr_d;
      vld_q  <= vld_d;
      id_q   <= id_d;
      v0_q   <= v0_d;
      v1_q   <= v1_d;
      d0_q   <= d0_d;
      d1_q   <= d1_d;
    end
  end
  assign bus.gnt0      = gnt0;
  assign bus.gnt1      = gnt1;
  assign bus.rom_addr  = addr_q;
  assign bus.rd_valid0 = v0_q;
  assign bus.rd_valid1 = v1_q;
  assign bus.rd_data0  = d0_q;
  assign bus.rd_data1  = d1_q;
  assign bus.busy      = |vld_q;
endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: runs identical stimulus into ROM_LAT=1 and ROM_LAT=3 instances and
// checks them against a per-edge acceptance log, directed tables and random traffic.
module tb_rom_arbiter;
  typedef struct {
    logic       rn, h, r0;
    logic [7:0] a0;
    logic       r1;
    logic [7:0] a1;
    logic       g0, g1, v0, v1;
    logic [7:0] d;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0, hold = 1'b0, req0 = 1'b0, req1 = 1'b0;
  logic [7:0] addr0 = 8'h00, addr1 = 8'h00;
  always #5 clk = ~clk;

  rom_arbiter_if #(.ADDR_W(8), .DATA_W(8)) if1 ();
  rom_arbiter_if #(.ADDR_W(8), .DATA_W(8)) if3 ();
  assign if1.hold = hold;   assign if3.hold = hold;
  assign if1.req0 = req0;   assign if3.req0 = req0;
  assign if1.req1 = req1;   assign if3.req1 = req1;
  assign if1.addr0 = addr0; assign if3.addr0 = addr0;
  assign if1.addr1 = addr1; assign if3.addr1 = addr1;

  logic [7:0] rq1;
  logic [7:0] p3 [3];
  always @(posedge clk) begin
    rq1   <= if1.rom_addr ^ 8'hA5;
    p3[0] <= if3.rom_addr;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign if1.rom_q = rq1;
  assign if3.rom_q = p3[2] ^ 8'hA5;

  rom_arbiter #(.ADDR_W(8), .DATA_W(8), .ROM_LAT(1)) dut1 (.sys_clk(clk), .sys_rst_n(rst_n), .bus(if1));
  rom_arbiter #(.ADDR_W(8), .DATA_W(8), .ROM_LAT(3)) dut3 (.sys_clk(clk), .sys_rst_n(rst_n), .bus(if3));

  logic [1:0] dg0, dg1, dv0, dv1, db;
  logic [7:0] dd0 [2], dd1 [2], dra [2];
  assign dg0 = {if3.gnt0, if1.gnt0};
  assign dg1 = {if3.gnt1, if1.gnt1};
  assign dv0 = {if3.rd_valid0, if1.rd_valid0};
  assign dv1 = {if3.rd_valid1, if1.rd_valid1};
  assign db  = {if3.busy, if1.busy};
  assign dd0[0] = if1.rd_data0; assign dd0[1] = if3.rd_data0;
  assign dd1[0] = if1.rd_data1; assign dd1[1] = if3.rd_data1;
  assign dra[0] = if1.rom_addr; assign dra[1] = if3.rom_addr;

  always @(negedge clk)
    assert (!(if1.gnt0 && if1.gnt1) && !(if3.gnt0 && if3.gnt1))
      else $error("FAIL gnt_onehot: both grants high");

  // reference model: a log of accepted reads indexed by edge number
  int         total = 0, bad = 0, n = 0, rst_edge = -1;
  int         lat [2] = '{1, 3};
  bit         acc_e [2048];
  bit         acc_id [2048];
  logic [7:0] acc_a [2048];
  logic       last = 1'b1, eg0, eg1;
  logic [7:0] raddr = 8'h00;
  logic [7:0] md0 [2], md1 [2];
  logic [1:0] sg0, sg1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", nm, n, act, exp);
    end
  endtask

  task automatic step(input logic rn, input logic h, input logic r0, input logic [7:0] a0,
                      input logic r1, input logic [7:0] a1);
    int  m, l;
    logic ev0, ev1, eb;
    rst_n = rn; hold = h; req0 = r0; addr0 = a0; req1 = r1; addr1 = a1;
    #1;
    eg0 = rn && !h && r0 && (!r1 || last);
    eg1 = rn && !h && r1 && !eg0;
    sg0 = dg0; sg1 = dg1;
    for (int i = 0; i < 2; i++) begin
      chk("gnt0", dg0[i], eg0);
      chk("gnt1", dg1[i], eg1);
    end
    @(posedge clk);
    n++;
    acc_e[n] = 1'b0;
    if (!rn) begin
      rst_edge = n; last = 1'b1; raddr = 8'h00;
      md0 = '{8'h00, 8'h00}; md1 = '{8'h00, 8'h00};
    end else if (eg0 || eg1) begin
      acc_e[n] = 1'b1; acc_id[n] = eg1; acc_a[n] = eg1 ? a1 : a0;
      last = eg1; raddr = acc_a[n];
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      l = lat[i];
      m = n - l - 1;
      ev0 = 1'b0; ev1 = 1'b0; eb = 1'b0;
      if (m > rst_edge && acc_e[m]) begin
        if (acc_id[m]) begin ev1 = 1'b1; md1[i] = acc_a[m] ^ 8'hA5; end
        else begin ev0 = 1'b1; md0[i] = acc_a[m] ^ 8'hA5; end
      end
      for (int j = n - l; j <= n; j++)
        if (j > rst_edge && j >= 0 && acc_e[j]) eb = 1'b1;
      chk("rd_valid0", dv0[i], ev0);
      chk("rd_valid1", dv1[i], ev1);
      chk("rd_data0", dd0[i], md0[i]);
      chk("rd_data1", dd1[i], md1[i]);
      chk("busy", db[i], eb);
      chk("rom_addr", dra[i], raddr);
    end
  endtask

  vec_t tv [22];
  logic seen;
  logic r0, r1, rn, h;
  logic [7:0] a0, a1;

  initial begin
    md0 = '{8'h00, 8'h00}; md1 = '{8'h00, 8'h00};
    tv[0]  = '{0, 0, 1, 8'h00, 0, 8'h00, 0, 0, 0, 0, 8'h00};
    tv[1]  = '{1, 0, 1, 8'h10, 0, 8'h00, 1, 0, 0, 0, 8'h00};
    tv[2]  = '{1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 8'h00};
    tv[3]  = '{1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 8'hB5};
    tv[4]  = '{0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 8'h00};
    tv[5]  = '{1, 0, 1, 8'h01, 1, 8'h02, 1, 0, 0, 0, 8'h00};
    tv[6]  = '{1, 0, 1, 8'h01, 1, 8'h02, 0, 1, 0, 0, 8'h00};
    tv[7]  = '{1, 0, 1, 8'h01, 1, 8'h02, 1, 0, 1, 0, 8'hA4};
    tv[8]  = '{1, 0, 1, 8'h01, 1, 8'h02, 0, 1, 0, 1, 8'hA7};
    tv[9]  = '{1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 8'hA4};
    tv[10] = '{1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 1, 8'hA7};
    tv[11] = '{1, 0, 0, 8'h00, 1, 8'hFE, 0, 1, 0, 0, 8'h00};
    tv[12] = '{1, 0, 0, 8'h00, 1, 8'hFF, 0, 1, 0, 0, 8'h00};
    tv[13] = '{1, 0, 0, 8'h00, 1, 8'h00, 0, 1, 0, 1, 8'h5B};
    tv[14] = '{1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 1, 8'h5A};
    tv[15] = '{1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 1, 8'hA5};
    tv[16] = '{1, 1, 1, 8'h44, 0, 8'h00, 0, 0, 0, 0, 8'h00};
    tv[17] = '{1, 1, 1, 8'h44, 0, 8'h00, 0, 0, 0, 0, 8'h00};
    tv[18] = '{1, 1, 1, 8'h44, 0, 8'h00, 0, 0, 0, 0, 8'h00};
    tv[19] = '{1, 0, 1, 8'h44, 0, 8'h00, 1, 0, 0, 0, 8'h00};
    tv[20] = '{1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 8'h00};
    tv[21] = '{1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 8'hE1};
    #1;
    for (int i = 0; i < 22; i++) begin
      step(tv[i].rn, tv[i].h, tv[i].r0, tv[i].a0, tv[i].r1, tv[i].a1);
      chk("tab_gnt0", sg0, {2{tv[i].g0}});
      chk("tab_gnt1", sg1, {2{tv[i].g1}});
      chk("tab_valid0_lat1", dv0[0], tv[i].v0);
      chk("tab_valid1_lat1", dv1[0], tv[i].v1);
      if (tv[i].v0) chk("tab_data0_lat1", dd0[0], tv[i].d);
      if (tv[i].v1) chk("tab_data1_lat1", dd1[0], tv[i].d);
    end
    // reset one edge after an accepted read must drop it entirely
    step(1, 0, 1, 8'h33, 0, 8'h00);
    chk("midflight_gnt0", sg0, 2'b11);
    step(0, 0, 0, 8'h00, 0, 8'h00);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 8'h00, 0, 8'h00);
      seen |= |{dv0, dv1};
    end
    chk("midflight_no_valid", seen, 1'b0);
    for (int i = 0; i < 2; i++) begin
      chk("midflight_rd_data0", dd0[i], 8'h00);
      chk("midflight_rom_addr", dra[i], 8'h00);
      chk("midflight_busy", db[i], 1'b0);
    end
    // random traffic: a requester keeps req/addr until its read is accepted
    r0 = 1'b0; r1 = 1'b0; a0 = 8'h00; a1 = 8'h00;
    for (int i = 0; i < 800; i++) begin
      rn = ($urandom_range(0, 59) != 0);
      h  = ($urandom_range(0, 7) == 0);
      if (!(r0 && !eg0)) begin r0 = 1'($urandom_range(0, 1)); a0 = 8'($urandom); end
      if (!(r1 && !eg1)) begin r1 = 1'($urandom_range(0, 1)); a1 = 8'($urandom); end
      step(rn, h, r0, a0, r1, a1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8: ROM address width.
REQ-002 The block SHALL have parameter DATA_W, default 8: ROM data width.
REQ-003 The block SHALL have parameter ROM_LAT, default 1, legal 1..4: clock cycles from rom_addr change to valid rom_q.
REQ-004 The block SHALL have port sys_clk, input, 1: the single clock; all logic on rising edge.
REQ-005 The block SHALL have port sys_rst_n, input, 1: reset; one clock, reset synchronous, active-low.
REQ-006 The block SHALL have port hold, input, 1: freeze arbitration while high.
REQ-007 The block SHALL have port req0, input, 1: requester 0 read request.
REQ-008 The block SHALL have port addr0, input, ADDR_W: requester 0 read address.
REQ-009 The block SHALL have port gnt0, output, 1: requester 0 address accepted at this edge.
REQ-010 The block SHALL have port rd_valid0, output, 1: one-cycle pulse, rd_data0 valid.
REQ-011 The block SHALL have port rd_data0, output, DATA_W: requester 0 read data.
REQ-012 The block SHALL have ports req1, addr1, gnt1, rd_valid1, rd_data1, with the same directions, widths and meanings for requester 1.
REQ-013 The block SHALL have port rom_addr, output, ADDR_W: registered address to the shared ROM.
REQ-014 The block SHALL have port rom_q, input, DATA_W: ROM read data.
REQ-015 The block SHALL have port busy, output, 1: high while any read is in flight.

Function
REQ-016 gnt0/gnt1 SHALL be combinational from req0/req1, hold and registered state only; at most one SHALL be high in any cycle.
REQ-017 Handshake: a read is accepted on the edge where req_x=1 and gnt_x=1; the requester holds req_x and addr_x stable until then.
REQ-018 With req_x held high after acceptance, a further read SHALL be accepted; a sole requester SHALL receive one grant every cycle.
REQ-019 hold=1 SHALL force gnt0=gnt1=0; in-flight reads still complete.
REQ-020 Arbitration: one requesting -> grant it; both requesting -> grant the one not granted last (round-robin pointer, 1 bit).
REQ-021 The pointer SHALL update only on an accepted read.
REQ-022 The pointer reset value SHALL make requester 0 win the first contested cycle.
REQ-023 On acceptance, rom_addr SHALL load addr_x at that edge and hold its value until the next acceptance.
REQ-024 A tag pipeline ROM_LAT+1 stages deep SHALL carry {valid, id} per accepted read.
REQ-025 rom_q SHALL be sampled ROM_LAT cycles after the rom_addr update, registered into rd_data_id, with rd_valid_id pulsing in that same cycle.
REQ-026 Total latency SHALL be: accepting edge k -> rd_valid high in the cycle after edge k+ROM_LAT+1.
REQ-027 Back-to-back reads SHALL be fully pipelined, with no bubbles; data SHALL return in acceptance order.
REQ-028 rd_data_x SHALL hold its last value between pulses; rd_valid0 and rd_valid1 SHALL never both be high.
REQ-029 busy SHALL be the OR of the tag valid bits.
REQ-030 No storage SHALL exist for refused requests; a refused requester simply keeps req high.

Reset
REQ-031 When sys_rst_n=0 at an edge: gnt0=gnt1=0, rom_addr=0, rd_data0=rd_data1=0, rd_valid0=rd_valid1=0, busy=0, all tag valids cleared, pointer set so requester 0 has priority.
REQ-032 Reset asserted mid-operation SHALL discard in-flight reads; no rd_valid pulse SHALL follow for them.
REQ-033 gnt SHALL be held 0 during the reset cycle.

Verification
REQ-034 Bench ROM model: rom_q = rom_addr XOR 8'hA5, delayed ROM_LAT cycles; scenarios run at ROM_LAT=1 and 3.
REQ-035 Single read: req0=1, addr0=8'h10 for one accepted cycle -> gnt0 that cycle; rd_valid0 pulse 2 cycles later (ROM_LAT=1) with rd_data0=8'hB5; rd_valid1 stays 0.
REQ-036 Contention: req0=req1=1 held 4 cycles, addr0=8'h01, addr1=8'h02 -> grants 0,1,0,1; rd_data sequence 8'hA4, 8'hA7, 8'hA4, 8'hA7 on alternating rd_valid0/rd_valid1.
REQ-037 Streaming: req1 only, addr1 stepping 8'hFE, 8'hFF, 8'h00 on consecutive cycles -> 3 consecutive rd_valid1 pulses with data 8'h5B, 8'h5A, 8'hA5; busy high throughout the stream.
REQ-038 Hold: hold=1 with req0=1 for 3 cycles -> gnt0=0 for all 3; release hold -> gnt0=1 in the next cycle.
REQ-039 Reset mid-flight: accept read at addr 8'h33, assert sys_rst_n=0 on the next edge -> no rd_valid pulse; rd_data0=0, rom_addr=0, busy=0.
REQ-040 Every scenario SHALL pass an assertion check that gnt0 and gnt1 are never both high.
